// File: rtl/rpn_pkg.sv
// Shared constants, opcode encoding, FSM states and legality limits for the RPN command sequencer.
package rpn_pkg;

    localparam int unsigned STK_DEPTH = 8;
    localparam int unsigned DEPTH_W   = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_PUSH = 3'b001;
    localparam logic [OP_W-1:0] OP_DROP = 3'b010;
    localparam logic [OP_W-1:0] OP_DUP  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OP_W-1:0] OP_AND  = 3'b110;
    localparam logic [OP_W-1:0] OP_PEEK = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP1 = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_WB   = 3'd4,
        ST_WB2  = 3'd5
    } state_e;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STK_DEPTH);

    // Occupancy window in which each opcode may be accepted
    localparam logic [DEPTH_W-1:0] MIN_NOP  = DEPTH_W'(0);
    localparam logic [DEPTH_W-1:0] MAX_NOP  = DEPTH_FULL;
    localparam logic [DEPTH_W-1:0] MIN_PUSH = DEPTH_W'(0);
    localparam logic [DEPTH_W-1:0] MAX_PUSH = DEPTH_W'(STK_DEPTH - 1);
    localparam logic [DEPTH_W-1:0] MIN_DROP = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] MAX_DROP = DEPTH_FULL;
    localparam logic [DEPTH_W-1:0] MIN_PEEK = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] MAX_PEEK = DEPTH_FULL;
    localparam logic [DEPTH_W-1:0] MIN_DUP  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] MAX_DUP  = DEPTH_W'(STK_DEPTH - 1);
    localparam logic [DEPTH_W-1:0] MIN_BIN  = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] MAX_BIN  = DEPTH_FULL;

    function automatic logic [DEPTH_W-1:0] op_min_depth(input logic [OP_W-1:0] op);
        case (op)
            OP_NOP:  return MIN_NOP;
            OP_PUSH: return MIN_PUSH;
            OP_DROP: return MIN_DROP;
            OP_PEEK: return MIN_PEEK;
            OP_DUP:  return MIN_DUP;
            default: return MIN_BIN;
        endcase
    endfunction

    function automatic logic [DEPTH_W-1:0] op_max_depth(input logic [OP_W-1:0] op);
        case (op)
            OP_NOP:  return MAX_NOP;
            OP_PUSH: return MAX_PUSH;
            OP_DROP: return MAX_DROP;
            OP_PEEK: return MAX_PEEK;
            OP_DUP:  return MAX_DUP;
            default: return MAX_BIN;
        endcase
    endfunction

    function automatic logic op_is_binary(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU: R = B op A, with A the former top of stack.
// Define RPN_CTRL_SAT_EN for unsigned saturating ADD/SUB; otherwise modulo 2^16.
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r_c
);

    logic [DATA_W-1:0] add_r;
    logic [DATA_W-1:0] sub_r;

`ifdef RPN_CTRL_SAT_EN
    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    assign sum_w  = {1'b0, b} + {1'b0, a};
    assign diff_w = {1'b0, b} - {1'b0, a};
    // Top bit is carry for the sum and borrow for the difference
    assign add_r  = sum_w[DATA_W]  ? '1 : sum_w[DATA_W-1:0];
    assign sub_r  = diff_w[DATA_W] ? '0 : diff_w[DATA_W-1:0];
`else
    assign add_r  = b + a;
    assign sub_r  = b - a;
`endif

    always_comb begin
        r_c = a;
        case (op)
            OP_ADD:  r_c = add_r;
            OP_SUB:  r_c = sub_r;
            OP_AND:  r_c = b & a;
            default: r_c = a;
        endcase
    end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN command sequencer in front of an 8-entry 16-bit stack; never over/underflows the stack.
// Build option RPN_CTRL_SAT_EN (handled in rpn_alu) selects saturating ADD/SUB.
module rpn_ctrl
    import rpn_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [DATA_W-1:0]   cmd_imm,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [DATA_W-1:0]   stk_value_in,
    input  logic [DATA_W-1:0]   stk_value_out,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    output logic [DEPTH_W-1:0]  depth,
    output logic                err
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   alu_r;
    logic [DATA_W-1:0]   stk_value_in_d, result_d;
    logic [DEPTH_W-1:0]  depth_d;
    logic                cmd_ready_d, stk_push_d, stk_pop_d, result_valid_d, err_d;
    logic                legal;

    // B is consumed straight off the stack read port during RD2
    rpn_alu u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (stk_value_out),
        .r_c (alu_r)
    );

    assign legal = (depth >= op_min_depth(cmd_op)) && (depth <= op_max_depth(cmd_op));

    // Next-state and next-output logic; strobes are set on entry to the state that owns them
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        cmd_ready_d    = 1'b0;
        stk_push_d     = 1'b0;
        stk_pop_d      = 1'b0;
        stk_value_in_d = '0;
        result_d       = result;
        result_valid_d = 1'b0;
        err_d          = err;
        depth_d        = depth;

        if (stk_push && !stk_pop) begin
            depth_d = depth + DEPTH_W'(1);
        end else if (stk_pop && !stk_push) begin
            depth_d = depth - DEPTH_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (cmd_op == OP_PUSH) begin
                        op_d           = cmd_op;
                        state_d        = ST_WB;
                        cmd_ready_d    = 1'b0;
                        stk_push_d     = 1'b1;
                        stk_value_in_d = cmd_imm;
                    end else if (cmd_op != OP_NOP) begin
                        op_d        = cmd_op;
                        state_d     = ST_POP1;
                        cmd_ready_d = 1'b0;
                        stk_pop_d   = 1'b1;
                    end
                end
            end
            ST_POP1: begin
                if (op_q == OP_DROP) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    state_d   = ST_RD1;
                    stk_pop_d = op_is_binary(op_q);
                end
            end
            ST_RD1: begin
                a_d = stk_value_out;
                if (op_is_binary(op_q)) begin
                    state_d = ST_RD2;
                end else begin
                    state_d        = ST_WB;
                    stk_push_d     = 1'b1;
                    stk_value_in_d = stk_value_out;
                    if (op_q == OP_PEEK) begin
                        result_d       = stk_value_out;
                        result_valid_d = 1'b1;
                    end
                end
            end
            ST_RD2: begin
                state_d        = ST_WB;
                stk_push_d     = 1'b1;
                stk_value_in_d = alu_r;
                result_d       = alu_r;
                result_valid_d = 1'b1;
            end
            ST_WB: begin
                if (op_q == OP_DUP) begin
                    state_d        = ST_WB2;
                    stk_push_d     = 1'b1;
                    stk_value_in_d = a_q;
                end else begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            a_q          <= '0;
            cmd_ready    <= 1'b1;
            stk_push     <= 1'b0;
            stk_pop      <= 1'b0;
            stk_value_in <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            depth        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            cmd_ready    <= cmd_ready_d;
            stk_push     <= stk_push_d;
            stk_pop      <= stk_pop_d;
            stk_value_in <= stk_value_in_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            err          <= err_d;
            depth        <= depth_d;
        end
    end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Randomized self-checking bench for rpn_ctrl against a queue-based RPN reference model.
module tb_rpn_ctrl;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3;
    localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, AND = 3'd6, PEEK = 3'd7;

`ifdef RPN_CTRL_SAT_EN
    localparam logic [15:0] EXP_WRAP = 16'hFFFF;
    localparam logic [15:0] EXP_BORROW = 16'h0000;
    localparam bit SAT = 1'b1;
`else
    localparam logic [15:0] EXP_WRAP = 16'h0001;
    localparam logic [15:0] EXP_BORROW = 16'hFFFF;
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_imm = 16'd0;
    logic        stk_push, stk_pop;
    logic [15:0] stk_value_in, stk_value_out;
    logic [15:0] result;
    logic        result_valid;
    logic [3:0]  depth;
    logic        err;

    int checks = 0;
    int errors = 0;

    rpn_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_imm       (cmd_imm),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_value_in  (stk_value_in),
        .stk_value_out (stk_value_out),
        .result        (result),
        .result_valid  (result_valid),
        .depth         (depth),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Behaviour of the downstream stack block: read port shows the entry at the pointer
    logic [15:0] mem [0:7];
    logic [3:0]  sp;
    always @(posedge clk) begin
        if (reset) begin
            sp <= 4'd0;
        end else if (stk_push) begin
            mem[sp[2:0]] <= stk_value_in;
            sp <= sp + 4'd1;
        end else if (stk_pop) begin
            sp <= sp - 4'd1;
        end
    end
    assign stk_value_out = mem[sp[2:0]];

    int push_cnt = 0, pop_cnt = 0, rv_cnt = 0, viol_cnt = 0;
    always @(negedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if (result_valid) rv_cnt <= rv_cnt + 1;
        if ((stk_push && stk_pop) || (!stk_push && stk_value_in != 16'd0))
            viol_cnt <= viol_cnt + 1;
    end

    // Reference model state
    logic [15:0] q[$];
    logic        m_err;
    logic [15:0] m_result;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        m_err = 1'b0;
        m_result = 16'd0;
        @(negedge clk);
        check("rst_depth", 32'(depth), 0);
        check("rst_err", 32'(err), 0);
        check("rst_result", 32'(result), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_strobes", {30'd0, stk_push, stk_pop}, 0);
        check("rst_vin", 32'(stk_value_in), 0);
        check("rst_ready", 32'(cmd_ready), 1);
    endtask

    // Issue one command, then compare latency, strobes and architectural state to the model
    task automatic do_cmd(input logic [2:0] op, input logic [15:0] imm);
        int  n, wait_n, lat, p0, o0, r0;
        int  e_push, e_pop, e_rv, e_lat;
        int  a, b, r;
        bit  ok;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 1);
        p0 = push_cnt; o0 = pop_cnt; r0 = rv_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_op = NOP; cmd_imm = 16'd0;
        lat = 1;
        @(negedge clk);
        while (!cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end

        n = q.size();
        e_push = 0; e_pop = 0; e_rv = 0; e_lat = 1;
        case (op)
            PUSH:    ok = (n < 8);
            DROP:    ok = (n >= 1);
            PEEK:    ok = (n >= 1);
            DUP:     ok = (n >= 1 && n <= 7);
            ADD, SUB, AND: ok = (n >= 2);
            default: ok = 1'b1;
        endcase
        if (!ok) begin
            m_err = 1'b1;
        end else begin
            case (op)
                PUSH: begin q.push_back(imm); e_push = 1; e_lat = 2; end
                DROP: begin void'(q.pop_back()); e_pop = 1; e_lat = 2; end
                PEEK: begin m_result = q[$]; e_push = 1; e_pop = 1; e_rv = 1; e_lat = 4; end
                DUP:  begin q.push_back(q[$]); e_push = 2; e_pop = 1; e_lat = 5; end
                ADD, SUB, AND: begin
                    a = int'(q.pop_back());
                    b = int'(q.pop_back());
                    if (op == ADD) begin
                        r = b + a;
                        if (r > 65535) r = SAT ? 65535 : r - 65536;
                    end else if (op == SUB) begin
                        r = b - a;
                        if (r < 0) r = SAT ? 0 : r + 65536;
                    end else begin
                        r = b & a;
                    end
                    q.push_back(16'(r));
                    m_result = 16'(r);
                    e_push = 1; e_pop = 2; e_rv = 1; e_lat = 5;
                end
                default: ;
            endcase
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("depth", 32'(depth), 32'(q.size()));
        check("err", 32'(err), 32'(m_err));
        check("result", 32'(result), 32'(m_result));
        check("push_count", 32'(push_cnt - p0), 32'(e_push));
        check("pop_count", 32'(pop_cnt - o0), 32'(e_pop));
        check("rv_pulses", 32'(rv_cnt - r0), 32'(e_rv));
    endtask

    initial begin
        int p0;
        logic [2:0]  rop;
        logic [15:0] rimm;

        do_reset();
        do_cmd(PUSH, 16'd5); do_cmd(PUSH, 16'd3); do_cmd(SUB, 16'd0);
        check("sub_5_3", 32'(result), 2);
        check("sub_depth", 32'(depth), 1);

        do_reset();
        do_cmd(PUSH, 16'hFFFF); do_cmd(PUSH, 16'd2); do_cmd(ADD, 16'd0);
        check("add_wrap", 32'(result), 32'(EXP_WRAP));
        do_cmd(PUSH, 16'd1); do_cmd(PUSH, 16'd2); do_cmd(SUB, 16'd0);
        check("sub_borrow", 32'(result), 32'(EXP_BORROW));

        do_reset();
        for (int i = 0; i < 8; i++) do_cmd(PUSH, 16'(i * 3 + 1));
        do_cmd(DUP, 16'd0);
        do_cmd(PUSH, 16'd7);
        check("full_err", 32'(err), 1);
        check("full_depth", 32'(depth), 8);

        do_reset();
        do_cmd(DUP, 16'd0); do_cmd(ADD, 16'd0);
        check("empty_err", 32'(err), 1);
        do_cmd(PUSH, 16'd9); do_cmd(PEEK, 16'd0);
        check("peek_9", 32'(result), 9);
        check("peek_depth", 32'(depth), 1);

        do_reset();
        do_cmd(PUSH, 16'd6); do_cmd(DUP, 16'd0); do_cmd(AND, 16'd0);
        check("and_6", 32'(result), 6);
        do_cmd(DROP, 16'd0);
        check("drop_depth", 32'(depth), 0);

        // Reset while the ADD sequence is in its RD1 cycle
        do_reset();
        do_cmd(PUSH, 16'd1); do_cmd(PUSH, 16'd2);
        p0 = push_cnt;
        cmd_valid = 1'b1; cmd_op = ADD;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_op = NOP;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_ready", 32'(cmd_ready), 1);
        check("midrst_depth", 32'(depth), 0);
        check("midrst_push", 32'(stk_push), 0);
        repeat (6) @(negedge clk);
        check("midrst_no_push", 32'(push_cnt - p0), 0);
        q.delete(); m_err = 1'b0; m_result = 16'd0;
        do_cmd(PUSH, 16'd4); do_cmd(PEEK, 16'd0);
        check("midrst_peek", 32'(result), 4);

        // Random command stream
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (q.size() < 2 && $urandom_range(0, 1) == 1) rop = PUSH;
            case ($urandom_range(0, 5))
                0:       rimm = 16'hFFFF;
                1:       rimm = 16'h0000;
                default: rimm = 16'($urandom);
            endcase
            do_cmd(rop, rimm);
            if (i == 200) do_reset();
        end

        check("strobe_rules", 32'(viol_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
